// File: rtl/cpu_commit_checker.sv
// Commit monitor for the single-cycle MIPS cpu: compares register writebacks and
// stores, in order, against a loadable expected trace and reports a verdict.
module cpu_commit_checker #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_W      = 5,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = 6,
    parameter int MAX_CYCLES = 26,
    parameter int CYC_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       exp_we,
    input  logic [IDX_W-1:0]           exp_waddr,
    input  logic [ADDR_W+DATA_W:0]     exp_wdata,
    input  logic [IDX_W:0]             exp_count,
    input  logic                       RegWrite,
    input  logic [REG_W-1:0]           write_reg,
    input  logic [DATA_W-1:0]          write_data,
    input  logic                       MemWrite,
    input  logic [ADDR_W-1:0]          addr_mem,
    input  logic [DATA_W-1:0]          write_mem,
    input  logic [DATA_W-1:0]          pc_next,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [2:0]                 fail_code,
    output logic [IDX_W:0]             event_idx,
    output logic [CYC_W-1:0]           cycle_cnt,
    output logic [DATA_W-1:0]          fail_pc
);

    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_DATA    = 3'd1;
    localparam logic [2:0] CODE_KIND    = 3'd2;
    localparam logic [2:0] CODE_EXTRA   = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT = 3'd4;
    localparam logic [2:0] CODE_DUAL    = 3'd5;

    localparam logic [IDX_W:0]   DEPTH_C   = (IDX_W + 1)'(DEPTH);
    localparam logic [CYC_W-1:0] LAST_CYC  = CYC_W'(MAX_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_SAT   = {CYC_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W:0]      count_q, count_d;
    logic [IDX_W:0]      idx_q, idx_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [2:0]          code_q, code_d;
    logic [DATA_W-1:0]   pc_q, pc_d;

    logic [ENT_W-1:0]    trace_mem [DEPTH];
    logic [ENT_W-1:0]    entry_s;
    logic                ent_kind_s;
    logic [ADDR_W-1:0]   ent_addr_s;
    logic [DATA_W-1:0]   ent_data_s;
    logic                reg_ev_s;
    logic                mem_ev_s;
    logic [2:0]          chk_code_s;
    logic                hit_s;
    logic [IDX_W:0]      count_in_s;

    // Trace RAM write port; contents survive reset so a trace can be re-run.
    always_ff @(posedge clk) begin
        if (!reset && exp_we && (state_q == ST_IDLE)) begin
            trace_mem[exp_waddr] <= exp_wdata;
        end
    end

    assign entry_s    = trace_mem[idx_q[IDX_W-1:0]];
    assign ent_kind_s = entry_s[ENT_W-1];
    assign ent_addr_s = entry_s[DATA_W +: ADDR_W];
    assign ent_data_s = entry_s[DATA_W-1:0];

    // Writes to $0 have no architectural effect, so they are not commit events.
    assign reg_ev_s   = RegWrite && (write_reg != {REG_W{1'b0}});
    assign mem_ev_s   = MemWrite;
    assign count_in_s = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;

    // Classify this cycle's commit against the expected entry, highest priority first.
    always_comb begin
        chk_code_s = CODE_NONE;
        hit_s      = 1'b0;
        if (reg_ev_s && mem_ev_s) begin
            chk_code_s = CODE_DUAL;
        end else if (reg_ev_s || mem_ev_s) begin
            if (idx_q == count_q) begin
                chk_code_s = CODE_EXTRA;
            end else if (ent_kind_s != mem_ev_s) begin
                chk_code_s = CODE_KIND;
            end else if (mem_ev_s) begin
                if ((ent_addr_s != addr_mem) || (ent_data_s != write_mem)) begin
                    chk_code_s = CODE_DATA;
                end else begin
                    hit_s = 1'b1;
                end
            end else begin
                if ((ent_addr_s[REG_W-1:0] != write_reg) || (ent_data_s != write_data)) begin
                    chk_code_s = CODE_DATA;
                end else begin
                    hit_s = 1'b1;
                end
            end
        end else begin
            chk_code_s = CODE_NONE;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= {(IDX_W + 1){1'b0}};
            idx_q   <= {(IDX_W + 1){1'b0}};
            cyc_q   <= {CYC_W{1'b0}};
            code_q  <= CODE_NONE;
            pc_q    <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            code_q  <= code_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state logic; the final window cycle still counts a completing event.
    always_comb begin
        logic [IDX_W:0] idx_next;
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        cyc_d    = cyc_q;
        code_d   = code_q;
        pc_d     = pc_q;
        idx_next = idx_q;
        case (state_q)
            ST_RUN: begin
                if (chk_code_s != CODE_NONE) begin
                    state_d = ST_FAIL;
                    code_d  = chk_code_s;
                    pc_d    = pc_next;
                end else begin
                    if (hit_s) begin
                        idx_next = idx_q + (IDX_W + 1)'(1);
                    end else begin
                        idx_next = idx_q;
                    end
                    idx_d = idx_next;
                    if (cyc_q == LAST_CYC) begin
                        if (idx_next == count_q) begin
                            state_d = ST_PASS;
                        end else begin
                            state_d = ST_FAIL;
                            code_d  = CODE_TIMEOUT;
                            pc_d    = pc_next;
                        end
                    end else if (cyc_q != CYC_SAT) begin
                        cyc_d = cyc_q + CYC_W'(1);
                    end else begin
                        cyc_d = cyc_q;
                    end
                end
            end
            ST_IDLE, ST_PASS, ST_FAIL: begin
                if (start) begin
                    state_d = ST_RUN;
                    count_d = count_in_s;
                    idx_d   = {(IDX_W + 1){1'b0}};
                    cyc_d   = {CYC_W{1'b0}};
                    code_d  = CODE_NONE;
                    pc_d    = {DATA_W{1'b0}};
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state_q)
            ST_RUN:  busy = 1'b1;
            ST_PASS: begin
                done = 1'b1;
                pass = 1'b1;
            end
            ST_FAIL: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign fail_code = code_q;
    assign event_idx = idx_q;
    assign cycle_cnt = cyc_q;
    assign fail_pc   = pc_q;

endmodule
